// File: rtl/emu_pkg.sv
// emu_pkg: shared constants, read-map offsets and step-controller state encoding.
package emu_pkg;
  localparam int DATA_W = 8;
  localparam int CYC_LO = 0;
  localparam int CYC_HI = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CAP = 2'd2} state_e;
endpackage

// File: rtl/emu_step_ctrl.sv
// emu_step_ctrl: command arbitration, burst counter and glitch-free DUT clock enable.
module emu_step_ctrl
  import emu_pkg::*;
#(
  parameter int AUTO_GET = 1
) (
  input  logic       clk_emu,
  input  logic       reset,
  input  logic       load_emu,
  input  logic       get_emu,
  input  logic       step_emu,
  input  logic [7:0] step_cnt_emu,
  output logic       busy_emu,
  output logic       dut_ce,
  output logic       load_o,
  output logic       cap_o
);
  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  always_ff @(posedge clk_emu or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // cnt holds the enables still owed, including the current RUN cycle; 0 encodes 256
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (step_emu && !load_emu && !get_emu) begin
        state_d = RUN;
        cnt_d   = {step_cnt_emu == 8'd0, step_cnt_emu};
      end
      RUN: begin
        cnt_d = cnt_q - 9'd1;
        if (cnt_q == 9'd1) state_d = (AUTO_GET != 0) ? CAP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    dut_ce   = state_q == RUN;
    busy_emu = state_q != IDLE;
    load_o   = state_q == IDLE && load_emu;
    cap_o    = state_q == CAP || (state_q == IDLE && !load_emu && get_emu);
  end
endmodule

// File: rtl/emu_transactor.sv
// emu_transactor: host register file, stimulus/capture registers, cycle counter and read mux.
module emu_transactor
  import emu_pkg::*;
#(
  parameter int NUM_STIM_ARRAY = 1,
  parameter int NUM_OUT_ARRAY  = 2,
  parameter int ADDR_W         = 3,
  parameter int AUTO_GET       = 1
) (
  input  logic                               clk_emu,
  input  logic                               reset,
  input  logic [DATA_W-1:0]                  Din_emu,
  output logic [DATA_W-1:0]                  Dout_emu,
  input  logic [ADDR_W-1:0]                  Addr_emu,
  input  logic                               wr_emu,
  input  logic                               load_emu,
  input  logic                               get_emu,
  input  logic                               step_emu,
  input  logic [7:0]                         step_cnt_emu,
  output logic                               busy_emu,
  output logic                               dut_ce,
  output logic [NUM_STIM_ARRAY*DATA_W-1:0]   stim_dut,
  input  logic [NUM_OUT_ARRAY*DATA_W-1:0]    vect_dut
);
  logic                            load, cap;
  logic [31:0]                     a;
  logic [DATA_W-1:0]               shadow_q [NUM_STIM_ARRAY];
  logic [DATA_W-1:0]               shadow_d [NUM_STIM_ARRAY];
  logic [DATA_W-1:0]               vect_q [NUM_OUT_ARRAY];
  logic [DATA_W-1:0]               vect_d [NUM_OUT_ARRAY];
  logic [NUM_STIM_ARRAY*DATA_W-1:0] stim_q, stim_d;
  logic [15:0]                     cyc_q, cyc_d;
  logic [DATA_W-1:0]               dout_q, dout_d;
  emu_step_ctrl #(.AUTO_GET(AUTO_GET)) u_ctrl (
    .clk_emu      (clk_emu),
    .reset        (reset),
    .load_emu     (load_emu),
    .get_emu      (get_emu),
    .step_emu     (step_emu),
    .step_cnt_emu (step_cnt_emu),
    .busy_emu     (busy_emu),
    .dut_ce       (dut_ce),
    .load_o       (load),
    .cap_o        (cap)
  );
  assign a        = 32'(Addr_emu);
  assign Dout_emu = dout_q;
  assign stim_dut = stim_q;
  // load copies the shadows as they stood before any same-cycle write
  always_comb begin
    shadow_d = shadow_q;
    vect_d   = vect_q;
    stim_d   = stim_q;
    dout_d   = '0;
    cyc_d    = dut_ce ? cyc_q + 16'd1 : cyc_q;
    for (int i = 0; i < NUM_STIM_ARRAY; i++) begin
      if (load) stim_d[DATA_W*i +: DATA_W] = shadow_q[i];
      if (wr_emu && a == i) shadow_d[i] = Din_emu;
    end
    for (int i = 0; i < NUM_OUT_ARRAY; i++) begin
      if (cap) vect_d[i] = vect_dut[DATA_W*i +: DATA_W];
      if (a == i) dout_d = vect_q[i];
    end
    if (a == NUM_OUT_ARRAY + CYC_LO) dout_d = cyc_q[7:0];
    if (a == NUM_OUT_ARRAY + CYC_HI) dout_d = cyc_q[15:8];
  end
  always_ff @(posedge clk_emu or posedge reset) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      vect_q   <= '{default: '0};
      stim_q   <= '0;
      cyc_q    <= '0;
      dout_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      vect_q   <= vect_d;
      stim_q   <= stim_d;
      cyc_q    <= cyc_d;
      dout_q   <= dout_d;
    end
  end
endmodule

// File: tb/tb_emu_transactor.sv
// tb_emu_transactor: random and directed stimulus against a cycle-level behavioural model.
module tb_emu_transactor;
  localparam int NS = 1;
  localparam int NO = 2;
  localparam int AW = 3;
  localparam int AG = 1;
  logic            clk_emu = 1'b0;
  logic            reset;
  logic [7:0]      Din_emu, Dout_emu, step_cnt_emu;
  logic [AW-1:0]   Addr_emu;
  logic            wr_emu, load_emu, get_emu, step_emu, busy_emu, dut_ce;
  logic [NS*8-1:0] stim_dut;
  logic [NO*8-1:0] vect_dut;
  int nvec = 0, nbad = 0;
  bit              use_fix = 0;
  logic [NO*8-1:0] vfix;
  logic [7:0]      m_shadow [NS];
  logic [7:0]      m_vect [NO];
  logic [NS*8-1:0] m_stim;
  logic [7:0]      m_dout;
  int              m_cyc, m_ce;
  bit              m_cap;

  emu_transactor #(.NUM_STIM_ARRAY(NS), .NUM_OUT_ARRAY(NO), .ADDR_W(AW), .AUTO_GET(AG)) dut (
    .clk_emu(clk_emu), .reset(reset), .Din_emu(Din_emu), .Dout_emu(Dout_emu),
    .Addr_emu(Addr_emu), .wr_emu(wr_emu), .load_emu(load_emu), .get_emu(get_emu),
    .step_emu(step_emu), .step_cnt_emu(step_cnt_emu), .busy_emu(busy_emu),
    .dut_ce(dut_ce), .stim_dut(stim_dut), .vect_dut(vect_dut)
  );

  always #5 clk_emu = ~clk_emu;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (m_shadow[i]) m_shadow[i] = '0;
    foreach (m_vect[i]) m_vect[i] = '0;
    m_stim = '0; m_dout = '0; m_cyc = 0; m_ce = 0; m_cap = 0;
  endfunction

  // One clock edge of the reference behaviour, from the inputs currently driven.
  function automatic void model_edge();
    bit idle = (m_ce == 0) && !m_cap;
    int ad = int'(Addr_emu);
    logic [7:0] rd;
    int ce_n = m_ce;
    bit cap_n = 0;
    if (ad < NO) rd = m_vect[ad];
    else if (ad == NO) rd = m_cyc[7:0];
    else if (ad == NO + 1) rd = m_cyc[15:8];
    else rd = 8'h00;
    if (idle && load_emu) for (int i = 0; i < NS; i++) m_stim[8*i +: 8] = m_shadow[i];
    if (wr_emu && ad < NS) m_shadow[ad] = Din_emu;
    if (m_cap || (idle && !load_emu && get_emu))
      for (int i = 0; i < NO; i++) m_vect[i] = vect_dut[8*i +: 8];
    if (m_ce > 0) begin
      m_cyc = (m_cyc + 1) % 65536;
      ce_n = m_ce - 1;
      cap_n = (m_ce == 1) && (AG != 0);
    end else if (idle && !load_emu && !get_emu && step_emu)
      ce_n = (step_cnt_emu == 0) ? 256 : int'(step_cnt_emu);
    m_ce = ce_n; m_cap = cap_n; m_dout = rd;
  endfunction

  task automatic tick(input logic w, input logic l, input logic g, input logic s,
                      input logic [7:0] d, input logic [7:0] c, input logic [AW-1:0] ad);
    chk("dut_ce", dut_ce, m_ce > 0);
    chk("busy", busy_emu, (m_ce > 0) || m_cap);
    chk("stim", stim_dut, m_stim);
    chk("dout", Dout_emu, m_dout);
    wr_emu = w; load_emu = l; get_emu = g; step_emu = s;
    Din_emu = d; step_cnt_emu = c; Addr_emu = ad;
    vect_dut = use_fix ? vfix : NO*8'($urandom);
    model_edge();
    @(negedge clk_emu);
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) tick(0, 0, 0, 0, 8'h00, 8'h00, '0);
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    @(negedge clk_emu);
    chk("rst_ce", dut_ce, 0);
    chk("rst_busy", busy_emu, 0);
    chk("rst_stim", stim_dut, 0);
    chk("rst_dout", Dout_emu, 0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    {wr_emu, load_emu, get_emu, step_emu} = '0;
    Din_emu = '0; step_cnt_emu = '0; Addr_emu = '0; vect_dut = '0;
    @(negedge clk_emu);
    sync_reset();
    // write, load, and an out-of-range write
    tick(1, 0, 0, 0, 8'h5A, 8'h00, 3'd0);
    tick(0, 1, 0, 0, 8'h00, 8'h00, 3'd0);
    chk("stim_5a", stim_dut, 8'h5A);
    tick(1, 0, 0, 0, 8'hFF, 8'h00, 3'd7);
    tick(0, 1, 0, 0, 8'h00, 8'h00, 3'd0);
    chk("stim_keep", stim_dut, 8'h5A);
    // 3-cycle burst with auto capture of a fixed vector
    use_fix = 1; vfix = 16'h1234;
    tick(0, 0, 0, 1, 8'h00, 8'd3, 3'd0);
    idle_ticks(4);
    tick(0, 0, 0, 0, 8'h00, 8'h00, 3'd0);
    chk("rd0", Dout_emu, 8'h34);
    tick(0, 0, 0, 0, 8'h00, 8'h00, 3'd1);
    chk("rd1", Dout_emu, 8'h12);
    use_fix = 0;
    // commands during RUN are dropped
    tick(0, 0, 0, 1, 8'h00, 8'd5, 3'd0);
    tick(1, 1, 1, 1, 8'h77, 8'd9, 3'd0);
    tick(0, 0, 1, 0, 8'h00, 8'd9, 3'd1);
    tick(0, 1, 0, 1, 8'h00, 8'd9, 3'd2);
    idle_ticks(6);
    // reset in the 2nd cycle of a 10-cycle burst
    tick(0, 0, 0, 1, 8'h00, 8'd10, 3'd2);
    tick(0, 0, 0, 0, 8'h00, 8'h00, 3'd2);
    #1 reset = 1'b1;
    #1 chk("mid_rst_ce", dut_ce, 0);
    chk("mid_rst_busy", busy_emu, 0);
    model_reset();
    @(negedge clk_emu);
    reset = 1'b0;
    for (int ad = 0; ad < 4; ad++) tick(0, 0, 0, 0, 8'h00, 8'h00, AW'(ad));
    // 256-cycle burst, then walk the counter to 0xFFFE and across the wrap
    tick(0, 0, 0, 1, 8'h00, 8'd0, 3'd0);
    idle_ticks(258);
    tick(0, 0, 0, 0, 8'h00, 8'h00, 3'd2);
    chk("cyc256_lo", Dout_emu, 8'h00);
    tick(0, 0, 0, 0, 8'h00, 8'h00, 3'd3);
    chk("cyc256_hi", Dout_emu, 8'h01);
    repeat (254) begin
      tick(0, 0, 0, 1, 8'h00, 8'd0, 3'd0);
      idle_ticks(258);
    end
    tick(0, 0, 0, 1, 8'h00, 8'd254, 3'd0);
    idle_ticks(256);
    tick(0, 0, 0, 0, 8'h00, 8'h00, 3'd2);
    chk("cyc_fffe", Dout_emu, 8'hFE);
    tick(0, 0, 0, 1, 8'h00, 8'd3, 3'd0);
    idle_ticks(5);
    tick(0, 0, 0, 0, 8'h00, 8'h00, 3'd2);
    chk("wrap_lo", Dout_emu, 8'h01);
    tick(0, 0, 0, 0, 8'h00, 8'h00, 3'd3);
    chk("wrap_hi", Dout_emu, 8'h00);
    // random traffic
    for (int n = 0; n < 3000; n++)
      tick(($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 16) == 0, ($urandom % 6) == 0,
           8'($urandom), (($urandom % 20) == 0) ? 8'd0 : 8'($urandom % 12), AW'($urandom));
    idle_ticks(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/emu_transactor.md
EMU_TRANSACTOR -- requirements
Module: emu_transactor

Interface
- REQ-001 Parameter NUM_STIM_ARRAY, default 1: number of 8-bit stimulus registers driven to the DUT.
- REQ-002 Parameter NUM_OUT_ARRAY, default 2: number of 8-bit output-capture registers read from the DUT.
- REQ-003 Parameter ADDR_W, default 3: width of Addr_emu; 2**ADDR_W SHALL be at least max(NUM_STIM_ARRAY, NUM_OUT_ARRAY+2).
- REQ-004 Parameter AUTO_GET, default 1: when 1, a capture SHALL follow every step burst automatically.
- REQ-005 Port clk_emu, input, 1: the single clock; all state is updated on its rising edge.
- REQ-006 Port reset, input, 1: asynchronous, active-high reset.
- REQ-007 Port Din_emu, input, 8: host write data.
- REQ-008 Port Dout_emu, output, 8: registered host read data.
- REQ-009 Port Addr_emu, input, ADDR_W: host register address.
- REQ-010 Port wr_emu, input, 1: writes Din_emu into the stimulus shadow register at Addr_emu.
- REQ-011 Port load_emu, input, 1: copies all shadow registers to the active stimulus.
- REQ-012 Port get_emu, input, 1: manual capture of DUT outputs.
- REQ-013 Port step_emu, input, 1: starts a burst of DUT clock enables.
- REQ-014 Port step_cnt_emu, input, 8: burst length; value 0 means 256.
- REQ-015 Port busy_emu, output, 1: high while a burst or capture is in progress.
- REQ-016 Port dut_ce, output, 1: DUT clock enable.
- REQ-017 Port stim_dut, output, NUM_STIM_ARRAY*8: active stimulus; register k occupies bits [8k+7:8k].
- REQ-018 Port vect_dut, input, NUM_OUT_ARRAY*8: DUT outputs, using the same packing as stim_dut.

Function
- REQ-019 FSM states SHALL be IDLE, RUN and CAP; busy_emu = (state != IDLE).
- REQ-020 Command priority in IDLE SHALL be load_emu > get_emu > step_emu, with at most one command executed per cycle.
- REQ-021 wr_emu SHALL be accepted in any state, including while busy.
- REQ-022 wr_emu to an address >= NUM_STIM_ARRAY SHALL be ignored.
- REQ-023 load_emu in IDLE SHALL update stim_dut on the next edge.
- REQ-024 load_emu, get_emu and step_emu asserted while busy SHALL be ignored and not queued.
- REQ-025 get_emu in IDLE SHALL register vect_dut into vectOut[0..NUM_OUT_ARRAY-1] on the next edge.
- REQ-026 step_emu in IDLE SHALL latch N = step_cnt_emu (0 -> 256) and move the FSM to RUN.
- REQ-027 dut_ce SHALL be high for exactly N consecutive cycles, starting the cycle after step_emu is sampled.
- REQ-028 dut_ce SHALL be decoded from the registered state only, so it is glitch-free.
- REQ-029 After the last enabled cycle the FSM SHALL enter CAP if AUTO_GET = 1, otherwise IDLE.
- REQ-030 CAP SHALL last one cycle, capture vect_dut into vectOut, then return to IDLE.
- REQ-031 A 16-bit cycle counter SHALL increment on every dut_ce cycle and wrap from 0xFFFF to 0x0000.
- REQ-032 Read map (Dout_emu updated every cycle from Addr_emu): addr < NUM_OUT_ARRAY returns vectOut[addr].
- REQ-033 Read map: NUM_OUT_ARRAY returns cycle counter [7:0]; NUM_OUT_ARRAY+1 returns [15:8]; any other address returns 8'h00.
- REQ-034 Read latency SHALL be one clk_emu cycle.
- REQ-035 A capture SHALL never change stim_dut, and load_emu SHALL never change vectOut.

Reset
- REQ-036 On reset the FSM SHALL return to IDLE, and dut_ce and busy_emu SHALL be 0.
- REQ-037 On reset Dout_emu, stim_dut, all shadow and vectOut registers, the burst counter and the cycle counter SHALL be 0.
- REQ-038 Reset asserted mid-burst SHALL drop dut_ce asynchronously, with no capture performed.

Structure
- REQ-039 Package emu_pkg SHALL hold the FSM state encoding, the constant DATA_W = 8 and the read-map offsets (CYC_LO = 0, CYC_HI = 1, each relative to NUM_OUT_ARRAY).
- REQ-040 Sub-module emu_step_ctrl SHALL contain the FSM, the burst counter and dut_ce generation; the register file and read mux SHALL stay in emu_transactor.

Verification
- REQ-041 Scenario: wr 0x5A @0, then load_emu -> stim_dut[7:0] = 0x5A one cycle later; wr @7 has no effect.
- REQ-042 Scenario: step_emu with cnt = 3, AUTO_GET = 1, vect_dut = 0x1234 -> dut_ce high 3 cycles, busy high 4 cycles, read @0 = 0x34, read @1 = 0x12.
- REQ-043 Scenario: step cnt = 0 -> exactly 256 dut_ce cycles; read @2 = 0x00, read @3 = 0x01.
- REQ-044 Scenario: load_emu, get_emu and step_emu pulsed during RUN -> ignored, and the burst length is unchanged.
- REQ-045 Scenario: reset asserted at the 2nd cycle of a 10-cycle burst -> dut_ce = 0 immediately, vectOut = 0, counter = 0.
- REQ-046 Scenario: cycle counter preset near wrap by bursts (0xFFFE + 3) -> reads 0x0001.
